ce_scheduler: RTL and testbench

//  Multi-channel fractional clock-enable scheduler. One master CLK, NCH channels (CPU/PPU/DSP).

---
 rtl/ce_sched_pkg.sv | 34 +++
 rtl/ce_sched_chan.sv | 106 ++++++++++
 rtl/ce_scheduler.sv | 120 ++++++++++++
 tb/tb_ce_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ce_sched_pkg
//  Description : Shared types and constants for the fractional clock-enable
//                scheduler (FSM state enum, ratio struct, channel indices).
//  Revision    : 1.0 - initial release
// ============================================================================
package ce_sched_pkg;

  // Scheduler run state: free-running, halted on a channel-0 boundary,
  // or running exactly one channel-0 period before halting again.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  // Fixed channel roles.
  localparam int CH_CPU = 0;
  localparam int CH_PPU = 1;
  localparam int CH_DSP = 2;

  // Accumulator width: one bit wider than the ratio fields so acc + OUT can
  // never wrap (acc < IN <= 2^32-1 and OUT <= 2^32-1).
  localparam int ACC_W = 33;

  // One clock ratio: OUT_CLK / IN_CLK.
  typedef struct packed {
    logic [31:0] in_clk;
    logic [31:0] out_clk;
  } ratio_t;

endpackage : ce_sched_pkg
`default_nettype wire

// File: rtl/ce_sched_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ce_sched_chan
//  Description : One fractional clock-enable channel. Accumulates OUT_CLK per
//                advancing cycle and fires CE whenever the sum reaches
//                IN_CLK. Holds an active and a shadow ratio; a shadow write is
//                applied on the channel's own CE edge so the output never
//                glitches mid-period.
//  Revision    : 1.0 - initial release
// ============================================================================
module ce_sched_chan
  import ce_sched_pkg::*;
#(
  parameter logic [31:0] DEF_IN_CLK  = 32'd21477270,
  parameter logic [31:0] DEF_OUT_CLK = 32'd3579545
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_adv,      // channel advances this cycle (RUN/STEP)
  input  logic   i_sync,     // zero the accumulator and CE
  input  logic   i_wr,       // shadow ratio write strobe
  input  ratio_t i_wr_data,  // shadow ratio write data
  output logic   o_ce,       // registered clock enable
  output logic   o_pend,     // shadow ratio waiting to be applied
  output logic   o_fire,     // CE will assert on the coming edge
  output logic   o_dis       // active IN_CLK is zero
);

  ratio_t           r_active;
  ratio_t           r_shadow;
  logic [ACC_W-1:0] r_acc;
  logic             r_pend;
  logic             r_ce;

  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_in_ext;
  logic             w_dis;
  logic             w_fast;
  logic             w_fire;
  logic             w_apply;

  // Fire / apply decision for the coming edge.
  always_comb begin
    w_in_ext = {1'b0, r_active.in_clk};
    w_sum    = r_acc + {1'b0, r_active.out_clk};
    w_dis    = (r_active.in_clk == 32'd0);
    // OUT >= IN fires every advancing cycle with the accumulator pinned at 0.
    w_fast   = (r_active.out_clk >= r_active.in_clk);
    w_fire   = i_adv && !i_sync && !w_dis && (w_sum >= w_in_ext);
    // Apply on the CE edge; a disabled or paused channel has no CE edge to
    // wait for, so it applies on the next edge instead. SYNC defers it.
    w_apply  = r_pend && !i_sync && (w_fire || w_dis || !i_adv);
  end

  // Accumulator, CE, active/shadow ratio and pending flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= '{in_clk: DEF_IN_CLK, out_clk: DEF_OUT_CLK};
      r_shadow <= '{in_clk: DEF_IN_CLK, out_clk: DEF_OUT_CLK};
      r_acc    <= '0;
      r_pend   <= 1'b0;
      r_ce     <= 1'b0;
    end else begin
      if (i_sync) begin
        r_acc <= '0;
        r_ce  <= 1'b0;
      end else if (w_apply) begin
        // Apply replaces this edge's accumulator update; CE still reports
        // the fire decided under the old ratio.
        r_active <= r_shadow;
        r_acc    <= '0;
        r_ce     <= w_fire;
      end else if (i_adv && !w_dis) begin
        r_ce <= w_fire;
        if (w_fast) begin
          r_acc <= '0;
        end else if (w_fire) begin
          r_acc <= w_sum - w_in_ext;
        end else begin
          r_acc <= w_sum;
        end
      end else begin
        r_ce <= 1'b0;
        if (w_dis) begin
          r_acc <= '0;
        end
      end

      // A write landing on the apply edge wins: the old shadow goes active
      // and the new data stays pending for the next apply.
      if (i_wr) begin
        r_shadow <= i_wr_data;
        r_pend   <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_ce   = r_ce;
  assign o_pend = r_pend;
  assign o_fire = w_fire;
  assign o_dis  = w_dis;

endmodule : ce_sched_chan
`default_nettype wire

// File: rtl/ce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ce_scheduler
//  Description : Multi-channel fractional clock-enable scheduler. Drives one
//                CE per core from the master clock, with run-time ratio
//                reconfiguration, pause / single-step on channel-0
//                boundaries and a global phase sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module ce_scheduler
  import ce_sched_pkg::*;
#(
  parameter int          NCH         = 3,
  parameter logic [31:0] DEF_IN_CLK  = 32'd21477270,
  parameter logic [31:0] DEF_OUT_CLK = 32'd3579545
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cfg_we,
  input  logic [$clog2(NCH):0] i_cfg_sel,
  input  logic [31:0]          i_cfg_in_clk,
  input  logic [31:0]          i_cfg_out_clk,
  output logic                 o_cfg_busy,
  input  logic                 i_pause_req,
  input  logic                 i_step,
  input  logic                 i_sync,
  output logic                 o_paused,
  output logic [NCH-1:0]       o_ce
);

  localparam int SEL_W = $clog2(NCH) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_adv;
  logic [NCH-1:0]   w_wr;
  logic [NCH-1:0]   w_pend;
  logic [NCH-1:0]   w_fire;
  logic [NCH-1:0]   w_dis;
  logic [NCH-1:0]   w_ce;
  ratio_t           w_wr_data;
  logic             w_ch0_edge;

  // Config write decode; selects at or above NCH hit no channel.
  always_comb begin
    w_wr_data = '{in_clk: i_cfg_in_clk, out_clk: i_cfg_out_clk};
    w_wr      = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wr[i] = i_cfg_we && (i_cfg_sel == SEL_W'(i));
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and channel advance. A disabled channel 0 has no CE, so every
  // edge counts as a channel-0 boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = (r_state == ST_RUN) || (r_state == ST_STEP);
    w_ch0_edge  = w_fire[CH_CPU] || w_dis[CH_CPU];
    if (!i_sync) begin
      case (r_state)
        ST_RUN: begin
          if (i_pause_req && w_ch0_edge) begin
            w_state_nxt = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (i_step) begin
            w_state_nxt = ST_STEP;
          end else if (!i_pause_req) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_STEP: begin
          if (w_ch0_edge) begin
            w_state_nxt = i_pause_req ? ST_PAUSED : ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_chan
      ce_sched_chan #(
        .DEF_IN_CLK  (DEF_IN_CLK),
        .DEF_OUT_CLK (DEF_OUT_CLK)
      ) u_chan (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_adv     (w_adv),
        .i_sync    (i_sync),
        .i_wr      (w_wr[g]),
        .i_wr_data (w_wr_data),
        .o_ce      (w_ce[g]),
        .o_pend    (w_pend[g]),
        .o_fire    (w_fire[g]),
        .o_dis     (w_dis[g])
      );
    end
  endgenerate

  assign o_ce       = w_ce;
  assign o_cfg_busy = |w_pend;
  assign o_paused   = (r_state == ST_PAUSED);

endmodule : ce_scheduler
`default_nettype wire

// File: tb/tb_ce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ce_scheduler
//  Description : Self-checking bench for ce_scheduler: directed scenarios
//                with literal expectations, then randomized traffic, all
//                tracked by a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ce_scheduler;

  localparam int     NCH     = 3;
  localparam longint DEF_IN  = 21477270;
  localparam longint DEF_OUT = 3579545;
  localparam int     MS_RUN = 0, MS_PAUSED = 1, MS_STEP = 2;

  logic           clk;
  logic           rst_n;
  logic           cfg_we;
  logic [2:0]     cfg_sel;
  logic [31:0]    cfg_in_clk;
  logic [31:0]    cfg_out_clk;
  logic           cfg_busy;
  logic           pause_req;
  logic           step;
  logic           sync;
  logic           paused;
  logic [NCH-1:0] ce;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  longint         m_acc [NCH];
  longint         m_in  [NCH];
  longint         m_out [NCH];
  longint         m_sin [NCH];
  longint         m_sout[NCH];
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_ce;
  int             m_st;

  ce_scheduler #(.NCH(NCH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cfg_we      (cfg_we),
    .i_cfg_sel     (cfg_sel),
    .i_cfg_in_clk  (cfg_in_clk),
    .i_cfg_out_clk (cfg_out_clk),
    .o_cfg_busy    (cfg_busy),
    .i_pause_req   (pause_req),
    .i_step        (step),
    .i_sync        (sync),
    .o_paused      (paused),
    .o_ce          (ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0; m_in[c] = DEF_IN; m_out[c] = DEF_OUT;
      m_sin[c] = DEF_IN; m_sout[c] = DEF_OUT;
    end
    m_pend = '0; m_ce = '0; m_st = MS_RUN;
  endtask

  // One master-clock edge of the specified behaviour.
  task automatic model_step();
    bit             adv;
    bit             b0;
    bit [NCH-1:0]   fire;
    bit [NCH-1:0]   dis;
    adv = (m_st != MS_PAUSED);
    for (int c = 0; c < NCH; c++) begin
      dis[c]  = (m_in[c] == 0);
      fire[c] = adv && !sync && !dis[c] && (m_acc[c] + m_out[c] >= m_in[c]);
    end
    b0 = fire[0] || dis[0];
    if (!sync) begin
      if (m_st == MS_RUN) begin
        if (pause_req && b0) m_st = MS_PAUSED;
      end else if (m_st == MS_PAUSED) begin
        if (step) m_st = MS_STEP;
        else if (!pause_req) m_st = MS_RUN;
      end else begin
        if (b0) m_st = pause_req ? MS_PAUSED : MS_RUN;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      bit apply;
      apply   = m_pend[c] && !sync && (fire[c] || dis[c] || !adv);
      m_ce[c] = fire[c];
      if (sync) m_acc[c] = 0;
      else if (apply) begin
        m_in[c] = m_sin[c]; m_out[c] = m_sout[c]; m_acc[c] = 0;
      end else if (dis[c]) m_acc[c] = 0;
      else if (adv) m_acc[c] = (m_out[c] >= m_in[c]) ? 0 : (m_acc[c] + m_out[c]) % m_in[c];
      if (cfg_we && cfg_sel == 3'(c)) begin
        m_sin[c] = cfg_in_clk; m_sout[c] = cfg_out_clk; m_pend[c] = 1'b1;
      end else if (apply) m_pend[c] = 1'b0;
    end
  endtask

  // Model advances on every edge out of reset.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("ce_vs_model",     64'(ce),       64'(m_ce));
      check("paused_vs_model", 64'(paused),   64'(m_st == MS_PAUSED));
      check("busy_vs_model",   64'(cfg_busy), 64'(|m_pend));
    end
  end

  task automatic cfg_write(input int sel, input longint in_clk, input longint out_clk);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 3'(sel);
    cfg_in_clk = 32'(in_clk); cfg_out_clk = 32'(out_clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (!cfg_busy) break;
      @(negedge clk);
    end
    check("busy_clear", 64'(cfg_busy), 64'd0);
  endtask

  task automatic wait_paused(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (paused) break;
    end
    check("enter_paused", 64'(paused), 64'd1);
  endtask

  int          first_k;
  int          cnt [NCH];
  logic [9:0]  pat;
  int          cnt_run;
  int          ce_cnt;
  int          mism;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_in_clk = '0; cfg_out_clk = '0;
    pause_req = 1'b0; step = 1'b0; sync = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ce",     64'(ce),       64'd0);
    check("rst_paused", 64'(paused),   64'd0);
    check("rst_busy",   64'(cfg_busy), 64'd0);
    rst_n = 1'b1;

    // 1. Default ratio: CE every 6th edge, 1000 CEs in 6000 cycles.
    first_k = 0;
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (ce[c]) cnt[c]++;
      if (ce[0] && first_k == 0) first_k = k;
    end
    check("def_first_ce", 64'(first_k), 64'd6);
    for (int c = 0; c < NCH; c++) check("def_ce_count", 64'(cnt[c]), 64'd1000);

    // 2. Reconfigure ch1 to 2/5 mid-run.
    cfg_write(1, 5, 2);
    for (int k = 0; k < 20; k++) begin
      if (ce[1]) break;
      check("busy_while_pend", 64'(cfg_busy), 64'd1);
      @(negedge clk);
    end
    check("ch1_apply_ce", 64'(ce[1]), 64'd1);
    check("busy_after_apply", 64'(cfg_busy), 64'd0);
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pat[k] = ce[1];
    end
    check("ch1_2of5_pattern", 64'(pat), 64'b1010010100);

    // 3. Edge ratios.
    cfg_write(0, 7, 7);
    cfg_write(1, 64'hFFFFFFFF, 64'hFFFFFFFF);
    cfg_write(2, 0, 5);
    wait_idle(30);
    mism = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ce !== 3'b011) mism++;
    end
    check("edge_ratio_cycles_wrong", 64'(mism), 64'd0);
    cfg_write(0, DEF_IN, DEF_OUT);
    cfg_write(1, DEF_IN, DEF_OUT);
    cfg_write(2, DEF_IN, DEF_OUT);
    wait_idle(30);

    // 4. Pause mid-period, then single-step one channel-0 period.
    repeat (2) @(negedge clk);
    pause_req = 1'b1;
    wait_paused(20);
    check("pause_on_ce0", 64'(ce[0]), 64'd1);
    mism = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ce !== '0 || !paused) mism++;
    end
    check("paused_quiet", 64'(mism), 64'd0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    cnt_run = 0; ce_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (ce[0]) ce_cnt++;
      if (paused) break;
      cnt_run++;
      @(negedge clk);
    end
    check("step_cycles", 64'(cnt_run), 64'd6);
    check("step_one_ce0", 64'(ce_cnt), 64'd1);
    check("step_repaused", 64'(paused), 64'd1);
    pause_req = 1'b0;
    @(negedge clk);
    check("released_run", 64'(paused), 64'd0);

    // 5. Sync with unequal ratios; ch0 and ch2 share 3/7.
    cfg_write(0, 7, 3);
    cfg_write(1, 5, 2);
    cfg_write(2, 7, 3);
    wait_idle(40);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync_ce_zero", 64'(ce), 64'd0);
    first_k = 0; mism = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ce[0] !== ce[2]) mism++;
      if (ce[0] && first_k == 0) first_k = k;
    end
    check("sync_coincident", 64'(mism), 64'd0);
    check("sync_first_ce0", 64'(first_k), 64'd3);

    // 6. Async reset mid-step with a write pending.
    pause_req = 1'b1;
    wait_paused(20);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_in_clk = 32'd9; cfg_out_clk = 32'd4;
    @(negedge clk);
    cfg_we = 1'b0;
    check("pend_before_rst", 64'(cfg_busy), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_ce",     64'(ce),       64'd0);
    check("async_rst_paused", 64'(paused),   64'd0);
    check("async_rst_busy",   64'(cfg_busy), 64'd0);
    pause_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mism = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6 && ce !== '0) mism++;
    end
    check("post_rst_early_ce", 64'(mism), 64'd0);
    check("post_rst_ce_at_6", 64'(ce), 64'b111);

    // Randomized traffic checked only by the model.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_sel     = 3'($urandom_range(0, 7));
      cfg_in_clk  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 9));
      cfg_out_clk = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) pause_req = ~pause_req;
      step = ($urandom_range(0, 7) == 0);
      sync = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    cfg_we = 1'b0; step = 1'b0; sync = 1'b0; pause_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ce_scheduler
`default_nettype wire
